jpu_regfile: RTL and testbench

//  Parametrised JPU general-purpose register file: 1 write port, 2 registered read ports (A/B).

---
 rtl/jpu_pkg.sv | 10 +
 rtl/jpu_regfile_if.sv | 29 ++
 rtl/jpu_regfile_clr.sv | 45 ++++
 rtl/jpu_regfile.sv | 80 ++++++++
 tb/tb_jpu_regfile.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/jpu_pkg.sv
// Shared JPU constants: default register-file geometry and clear-sequencer states.
package jpu_pkg;
  localparam int JPU_WORD_W = 16;
  localparam int JPU_NREGS  = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } clr_state_e;
endpackage

// File: rtl/jpu_regfile_if.sv
// Decode/ALU-facing bus of the JPU register file: one write port, paired A/B reads.
interface jpu_regfile_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             enable;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr_a;
  logic [AW-1:0]    rd_addr_b;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid;
  logic             ready;

  modport master (
    output enable, wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid, ready
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid, ready
  );
endinterface

// File: rtl/jpu_regfile_clr.sv
// Post-reset clear sequencer: sweeps every entry to zero once, then holds ready.
module jpu_regfile_clr
  import jpu_pkg::*;
#(
  parameter int DEPTH = JPU_NREGS
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic                     ready
);
  localparam int AW = $clog2(DEPTH);

  clr_state_e    state, state_nx;
  logic [AW-1:0] clr_ptr, ptr_nx;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = clr_ptr;
    clr_we   = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        ptr_nx = clr_ptr + AW'(1);
        if (clr_ptr == AW'(DEPTH - 1)) state_nx = RUN;
      end
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  assign clr_addr = clr_ptr;
  assign ready    = (state == RUN);
endmodule

// File: rtl/jpu_regfile.sv
// JPU general-purpose register file, 1W/2R with registered reads and a post-reset clear.
// Build option: JPU_REGFILE_BYPASS_EN forwards same-cycle write data to a matching read.
module jpu_regfile
  import jpu_pkg::*;
#(
  parameter int WIDTH    = JPU_WORD_W,
  parameter int DEPTH    = JPU_NREGS,
  parameter int ZERO_REG = 0
) (
  input  logic          clock,
  input  logic          reset_n,
  jpu_regfile_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_we, ready;
  logic [AW-1:0]    clr_addr;
  logic             wr_acc, rd_acc, wr_keep;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] q_a, q_b;
  logic             q_vld;

  jpu_regfile_clr #(.DEPTH(DEPTH)) u_clr (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wr_acc  = ready & bus.enable & bus.wr_en;
  assign rd_acc  = ready & bus.enable & bus.rd_en;
  assign wr_keep = wr_acc & ~((ZERO_REG != 0) && (bus.wr_addr == '0));

  // Clear and user writes never overlap: clr_we is only high while ready is low.
  assign mem_we   = clr_we | wr_keep;
  assign mem_addr = clr_we ? clr_addr : bus.wr_addr;
  assign mem_din  = clr_we ? '0 : bus.wr_data;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  always_comb begin
    rd_a = mem[bus.rd_addr_a];
    rd_b = mem[bus.rd_addr_b];
`ifdef JPU_REGFILE_BYPASS_EN
    if (wr_acc && (bus.wr_addr == bus.rd_addr_a)) rd_a = bus.wr_data;
    if (wr_acc && (bus.wr_addr == bus.rd_addr_b)) rd_b = bus.wr_data;
`else
`endif
    // Zero register wins over forwarding as well as over stored contents.
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) rd_a = '0;
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) rd_b = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q_vld <= 1'b0;
      q_a   <= '0;
      q_b   <= '0;
    end else begin
      q_vld <= rd_acc;
      if (rd_acc) begin
        q_a <= rd_a;
        q_b <= rd_b;
      end
    end
  end

  assign bus.rd_data_a = q_a;
  assign bus.rd_data_b = q_b;
  assign bus.rd_valid  = q_vld;
  assign bus.ready     = ready;
endmodule

// File: tb/tb_jpu_regfile.sv
// Bench: 16x8 file (no zero reg) and 32x32 file (zero reg) run side by side against an array model.
module tb_jpu_regfile;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  jpu_regfile_if #(.WIDTH(16), .DEPTH(8))  b0 ();
  jpu_regfile_if #(.WIDTH(32), .DEPTH(32)) b1 ();

  jpu_regfile #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(b0));
  jpu_regfile #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1));

  // Stimulus per instance (index 0 = 16x8, 1 = 32x32)
  logic        en [2], we [2], re [2];
  logic [4:0]  wa [2], ra [2], rb [2];
  logic [31:0] wd [2];

  assign b0.enable = en[0];  assign b1.enable = en[1];
  assign b0.wr_en  = we[0];  assign b1.wr_en  = we[1];
  assign b0.rd_en  = re[0];  assign b1.rd_en  = re[1];
  assign b0.wr_addr   = wa[0][2:0]; assign b1.wr_addr   = wa[1];
  assign b0.rd_addr_a = ra[0][2:0]; assign b1.rd_addr_a = ra[1];
  assign b0.rd_addr_b = rb[0][2:0]; assign b1.rd_addr_b = rb[1];
  assign b0.wr_data   = wd[0][15:0]; assign b1.wr_data  = wd[1];

  logic [31:0] o_a [2], o_b [2];
  logic        o_v [2], o_r [2];
  assign o_a[0] = {16'h0, b0.rd_data_a}; assign o_a[1] = b1.rd_data_a;
  assign o_b[0] = {16'h0, b0.rd_data_b}; assign o_b[1] = b1.rd_data_b;
  assign o_v[0] = b0.rd_valid; assign o_v[1] = b1.rd_valid;
  assign o_r[0] = b0.ready;    assign o_r[1] = b1.ready;

  // Reference model state
  logic [31:0] mm [2][32];
  int          cnt [2];
  logic        e_r [2], e_v [2];
  logic [31:0] e_a [2], e_b [2];

  int nchk = 0, nfail = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input int d, input logic [4:0] a, input logic wacc,
                                           input logic [4:0] wad, input logic [31:0] wdat);
    logic [31:0] v;
    v = mm[d][a];
`ifdef JPU_REGFILE_BYPASS_EN
    if (wacc && wad == a) v = wdat;
`endif
    if (d == 1 && a == 5'd0) v = 32'h0;
    return v;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int          depth;
      logic [31:0] mask;
      logic [4:0]  am, wam, ram, rbm;
      logic        racc, wacc;
      depth = (d == 1) ? 32 : 8;
      mask  = (d == 1) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      am    = 5'(depth - 1);
      if (!reset_n) begin
        cnt[d] = 0; e_r[d] = 1'b0; e_v[d] = 1'b0; e_a[d] = '0; e_b[d] = '0;
      end else if (!e_r[d]) begin
        mm[d][cnt[d]] = '0;
        cnt[d]++;
        if (cnt[d] == depth) e_r[d] = 1'b1;
        e_v[d] = 1'b0;
      end else begin
        wam  = wa[d] & am; ram = ra[d] & am; rbm = rb[d] & am;
        racc = en[d] & re[d];
        wacc = en[d] & we[d];
        e_v[d] = racc;
        if (racc) begin
          e_a[d] = model_rd(d, ram, wacc, wam, wd[d] & mask);
          e_b[d] = model_rd(d, rbm, wacc, wam, wd[d] & mask);
        end
        if (wacc && !(d == 1 && wam == 5'd0)) mm[d][wam] = wd[d] & mask;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("ready", d, {31'h0, o_r[d]}, {31'h0, e_r[d]});
      chk("rd_valid", d, {31'h0, o_v[d]}, {31'h0, e_v[d]});
      chk("rd_data_a", d, o_a[d], e_a[d]);
      chk("rd_data_b", d, o_b[d], e_b[d]);
    end
  endtask

  task automatic idle(input int d);
    en[d] = 1'b0; we[d] = 1'b0; re[d] = 1'b0;
    wa[d] = '0; ra[d] = '0; rb[d] = '0; wd[d] = '0;
  endtask

  task automatic wr(input int d, input logic [4:0] a, input logic [31:0] v);
    idle(d); en[d] = 1'b1; we[d] = 1'b1; wa[d] = a; wd[d] = v;
  endtask

  task automatic rd(input int d, input logic [4:0] a, input logic [4:0] b);
    idle(d); en[d] = 1'b1; re[d] = 1'b1; ra[d] = a; rb[d] = b;
  endtask

  logic [31:0] exp_byp;

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle(d);
      cnt[d] = 0; e_r[d] = 1'b0; e_v[d] = 1'b0; e_a[d] = '0; e_b[d] = '0;
      for (int i = 0; i < 32; i++) mm[d][i] = 32'hx;
    end
    reset_n = 1'b0;
    tick(); tick();

    // Clear sweep of the 16x8 file; accesses during sweep are ignored.
    reset_n = 1'b1;
    wr(0, 5'd2, 32'h5555);
    for (int i = 0; i < 7; i++) tick();
    chk("ready_pre", 0, {31'h0, o_r[0]}, 32'h0);
    tick();
    chk("ready_at8", 0, {31'h0, o_r[0]}, 32'h1);

    // Every address reads zero, valid pulses once.
    for (int i = 0; i < 8; i++) begin
      rd(0, 5'(i), 5'(7 - i)); tick();
      chk("sweep_zero", 0, o_a[0], 32'h0);
      idle(0); tick();
    end
    while (!e_r[1]) tick();
    for (int i = 0; i < 32; i++) begin
      rd(1, 5'(i), 5'(i)); tick();
      chk("sweep_zero", 1, o_a[1], 32'h0);
    end
    idle(1);

    // Write then dual read; valid drops while data holds.
    wr(0, 5'd1, 32'hFF31); wr(1, 5'd1, 32'h0000FF31); tick();
    wr(0, 5'd3, 32'h6543); wr(1, 5'd31, 32'hDEADBEEF); tick();
    rd(0, 5'd1, 5'd3); rd(1, 5'd1, 5'd31); tick();
    chk("rd_a_ff31", 0, o_a[0], 32'hFF31);
    chk("rd_b_6543", 0, o_b[0], 32'h6543);
    chk("rd_b_beef", 1, o_b[1], 32'hDEADBEEF);
    idle(0); idle(1); tick();
    chk("vld_drop", 0, {31'h0, o_v[0]}, 32'h0);
    chk("data_hold", 0, o_a[0], 32'hFF31);

    // Same-cycle write/read of r5.
`ifdef JPU_REGFILE_BYPASS_EN
    exp_byp = 32'hBEEF;
`else
    exp_byp = 32'h0;
`endif
    wr(0, 5'd5, 32'hBEEF); re[0] = 1'b1; ra[0] = 5'd5; rb[0] = 5'd5; tick();
    chk("same_cyc", 0, o_a[0], exp_byp);
    rd(0, 5'd5, 5'd1); tick();
    chk("after_wr", 0, o_a[0], 32'hBEEF);

    // Zero register: write to r0 dropped, reads (incl. same-cycle) return 0.
    wr(1, 5'd0, 32'h1234); re[1] = 1'b1; ra[1] = 5'd0; rb[1] = 5'd0; tick();
    chk("zr_same", 1, o_a[1], 32'h0);
    rd(1, 5'd0, 5'd31); tick();
    chk("zr_read", 1, o_a[1], 32'h0);

    // enable low blocks everything.
    wr(0, 5'd2, 32'hAAAA); re[0] = 1'b1; ra[0] = 5'd2; en[0] = 1'b0; tick();
    chk("en_off_vld", 0, {31'h0, o_v[0]}, 32'h0);
    rd(0, 5'd2, 5'd2); tick();
    chk("en_off_mem", 0, o_a[0], 32'h0);

    // Random traffic on both files.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        en[d] = ($urandom_range(0, 7) != 0);
        we[d] = $urandom_range(0, 1);
        re[d] = $urandom_range(0, 1);
        wa[d] = 5'($urandom); ra[d] = 5'($urandom); rb[d] = 5'($urandom);
        if ($urandom_range(0, 3) == 0) ra[d] = wa[d];
        wd[d] = $urandom;
      end
      tick();
    end

    // Reset at sweep cycle 4 restarts the sweep; writes during sweep dropped.
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    reset_n = 1'b0; tick();
    reset_n = 1'b1;
    wr(0, 5'd4, 32'h7777); re[0] = 1'b1; wr(1, 5'd9, 32'h7777);
    for (int i = 0; i < 7; i++) tick();
    chk("rst_mid_rdy", 0, {31'h0, o_r[0]}, 32'h0);
    tick();
    chk("rst_mid_rdy1", 0, {31'h0, o_r[0]}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd(0, 5'(i), 5'(i)); tick();
      chk("post_rst_zero", 0, o_b[0], 32'h0);
    end
    idle(0);
    while (!e_r[1]) tick();
    rd(1, 5'd9, 5'd31); tick();
    chk("post_rst_zero", 1, o_a[1], 32'h0);
    idle(1); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
